sigma_delta_cic_decimator: RTL and testbench

Consumes the 1-bit sigma-delta stream from the 1-bit ADC sampling flop (registered comparator output, one bit per `clk_80mhz` cycle). It runs the stream through an ORDER-stage CIC decimator and emits signed multi-bit samples at i_clk/DECIM, each with a one-cycle valid strobe. It is the first multi-bit stage of the receive chain and feeds downstream filtering/mixing.

---
 rtl/sigma_delta_cic_decimator.sv | 105 ++++++++++
 tb/tb_sigma_delta_cic_decimator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_cic_decimator.sv
// sigma_delta_cic_decimator
// Converts a 1-bit sigma-delta stream (one bit per i_clk) into signed
// multi-bit samples at i_clk/DECIM with an ORDER-stage CIC decimator.
//
// Output handshake: o_valid is a one-cycle strobe with no ready/backpressure.
// o_sample carries a new value exactly in the cycle o_valid is high, and it
// holds that value until the next strobe. The consumer must take it then.
module sigma_delta_cic_decimator #(
  parameter int DECIM = 256,
  parameter int ORDER = 3,
  parameter int OUT_W = 26
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_bit,
  output logic [OUT_W-1:0] o_sample,
  output logic             o_valid
);

  // Counter width is log2(R); the internal width carries N*log2(R) bits of
  // growth plus sign and one headroom bit so that +R^N is representable.
  localparam int CNT_W = $clog2(DECIM);
  localparam int W     = ORDER * CNT_W + 2;

  logic [W-1:0]     w_x;
  logic [W-1:0]     r_int [ORDER];
  logic [W-1:0]     r_dly [ORDER];
  logic [W-1:0]     w_comb_in [ORDER];
  logic [W-1:0]     w_acc;
  logic [W-1:0]     w_comb_out;
  logic [CNT_W-1:0] r_cnt;
  logic             w_event;
  logic [OUT_W-1:0] r_sample;
  logic             r_valid;

  // Bit 1 maps to +1, bit 0 maps to -1 (all ones in two's complement).
  assign w_x = i_bit ? W'(1) : {W{1'b1}};

  // The event edge is the last edge of each R-cycle window.
  assign w_event = (r_cnt == CNT_W'(DECIM - 1));

  // Integrator chain: each stage adds the previous stage's pre-edge value;
  // wrap-around is intended and is cancelled by the comb section.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < ORDER; k++) begin
        r_int[k] <= '0;
      end
    end else begin
      r_int[0] <= r_int[0] + w_x;
      for (int k = 1; k < ORDER; k++) begin
        r_int[k] <= r_int[k] + r_int[k-1];
      end
    end
  end

  // Decimation counter: free-running modulo R (R is a power of two).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Comb chain: c0 is the last integrator, each stage subtracts its delay.
  always_comb begin
    w_acc = r_int[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      w_comb_in[k] = w_acc;
      w_acc        = w_acc - r_dly[k];
    end
    w_comb_out = w_acc;
  end

  // Comb delays capture their stage inputs only on decimation events.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < ORDER; k++) begin
        r_dly[k] <= '0;
      end
    end else if (w_event) begin
      for (int k = 0; k < ORDER; k++) begin
        r_dly[k] <= w_comb_in[k];
      end
    end
  end

  // Output register: MSB-aligned truncation on events, hold otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_event;
      if (w_event) begin
        r_sample <= w_comb_out[W-1 -: OUT_W];
      end
    end
  end

  assign o_sample = r_sample;
  assign o_valid  = r_valid;

endmodule

// File: tb/tb_sigma_delta_cic_decimator.sv
// Bench for sigma_delta_cic_decimator: a small instance (R=4, N=3, 8-bit)
// and a default instance (R=256, N=3, 26-bit), checked against a reference
// model built on 64-bit integers that never wrap in these run lengths.
module tb_sigma_delta_cic_decimator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s = 1'b1, bit_s = 1'b0;
  logic       rst_d = 1'b1, bit_d = 1'b0;
  logic [7:0] sample_s;
  logic       valid_s;
  logic [25:0] sample_d;
  logic        valid_d;

  sigma_delta_cic_decimator #(.DECIM(4), .ORDER(3), .OUT_W(8)) dut_s (
    .i_clk(clk), .i_rst(rst_s), .i_bit(bit_s),
    .o_sample(sample_s), .o_valid(valid_s)
  );

  sigma_delta_cic_decimator #(.DECIM(256), .ORDER(3), .OUT_W(26)) dut_d (
    .i_clk(clk), .i_rst(rst_d), .i_bit(bit_d),
    .o_sample(sample_d), .o_valid(valid_d)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // ---------------- reference model ----------------
  localparam int ORD = 3;
  int     p_r  [2] = '{4, 256};
  int     p_sh [2] = '{0, 0};      // W - OUT_W for each instance
  longint m_int [2][ORD];
  longint m_dly [2][ORD];
  int     m_cnt [2];
  longint m_out [2];
  logic   m_val [2];
  logic [31:0] exp_q_s[$];
  logic [31:0] exp_q_d[$];

  task automatic model_step(input int inst, input logic b, input logic rst);
    longint c, c2;
    if (rst) begin
      for (int k = 0; k < ORD; k++) begin
        m_int[inst][k] = 0;
        m_dly[inst][k] = 0;
      end
      m_cnt[inst] = 0;
      m_out[inst] = 0;
      m_val[inst] = 1'b0;
    end else begin
      if (m_cnt[inst] == p_r[inst] - 1) begin
        c = m_int[inst][ORD-1];
        for (int k = 0; k < ORD; k++) begin
          c2 = c - m_dly[inst][k];
          m_dly[inst][k] = c;
          c = c2;
        end
        m_out[inst] = c >>> p_sh[inst];
        m_val[inst] = 1'b1;
        if (inst == 0) exp_q_s.push_back(32'(m_out[inst]));
        else           exp_q_d.push_back(32'(m_out[inst]));
      end else begin
        m_val[inst] = 1'b0;
      end
      for (int k = ORD - 1; k >= 1; k--) begin
        m_int[inst][k] = m_int[inst][k] + m_int[inst][k-1];
      end
      m_int[inst][0] = m_int[inst][0] + (b ? 64'sd1 : -64'sd1);
      m_cnt[inst] = (m_cnt[inst] + 1) % p_r[inst];
    end
  endtask

  // ---------------- per-phase bookkeeping ----------------
  int     ph_edge = 0;
  int     vcnt = 0;
  logic   settle_chk = 1'b0;
  int     settle_val = 0;
  longint settle_sum = 0;
  int     settle_n = 0;

  // ---------------- driver ----------------
  task automatic run_cycle(input int inst, input logic b, input logic rst);
    logic [31:0] obs;
    logic        ov;
    logic [31:0] e;
    if (inst == 0) begin
      bit_s = b; rst_s = rst; rst_d = 1'b1; bit_d = 1'b0;
    end else begin
      bit_d = b; rst_d = rst; rst_s = 1'b1; bit_s = 1'b0;
    end
    model_step(inst, b, rst);
    @(posedge clk);
    @(negedge clk);
    if (inst == 0) begin
      obs = {{24{sample_s[7]}}, sample_s};
      ov  = valid_s;
    end else begin
      obs = {{6{sample_d[25]}}, sample_d};
      ov  = valid_d;
    end
    check_eq("valid", {31'd0, ov}, {31'd0, m_val[inst]});
    check_eq("sample_reg", obs, 32'(m_out[inst]));
    if (rst) begin
      check_eq("rst_valid", {31'd0, ov}, 32'd0);
      check_eq("rst_sample", obs, 32'd0);
      ph_edge = 0;
      vcnt    = 0;
    end else begin
      if (ov) begin
        if (inst == 0) begin
          if (exp_q_s.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
          else begin
            e = exp_q_s.pop_front();
            check_eq("sb_sample_s", obs, e);
          end
        end else begin
          if (exp_q_d.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
          else begin
            e = exp_q_d.pop_front();
            check_eq("sb_sample_d", obs, e);
          end
        end
        check_eq("valid_edge", 32'(ph_edge), 32'(vcnt * p_r[inst] + p_r[inst] - 1));
        vcnt++;
        if (vcnt >= 4) begin
          if (settle_chk) check_eq("settled", obs, 32'(settle_val));
          settle_sum += longint'($signed(obs));
          settle_n++;
        end
      end
      ph_edge++;
    end
  endtask

  task automatic end_phase(input string tag);
    check_eq(tag, 32'(exp_q_s.size() + exp_q_d.size()), 32'd0);
    exp_q_s.delete();
    exp_q_d.delete();
  endtask

  // kind: 0 = all ones, 1 = all zeros, 2 = alternating from 1,
  //       3 = density 0.75 (one random zero per group of four)
  task automatic run_phase(input int inst, input int kind, input int ncyc,
                           input logic chk, input int val, input string tag);
    int   zpos;
    logic b;
    settle_chk = chk;
    settle_val = val;
    settle_sum = 0;
    settle_n   = 0;
    zpos       = 0;
    run_cycle(inst, 1'b0, 1'b1);
    run_cycle(inst, 1'b0, 1'b1);
    for (int i = 0; i < ncyc; i++) begin
      case (kind)
        0: b = 1'b1;
        1: b = 1'b0;
        2: b = (i % 2 == 0);
        default: begin
          if (i % 4 == 0) zpos = $urandom_range(0, 3);
          b = ((i % 4) != zpos);
        end
      endcase
      run_cycle(inst, b, 1'b0);
    end
    end_phase(tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    longint mean;
    logic   mean_ok;
    p_sh[0] = 0;   // W = 3*2+2 = 8, OUT_W = 8
    p_sh[1] = 0;   // W = 3*8+2 = 26, OUT_W = 26
    for (int i = 0; i < 2; i++) model_step(i, 1'b0, 1'b1);
    repeat (2) @(negedge clk);

    run_phase(0, 0, 48, 1'b1, 64, "q_ones");
    check_eq("ones_valid_count", 32'(vcnt), 32'd12);
    run_phase(0, 1, 48, 1'b1, -64, "q_zeros");
    run_phase(0, 2, 48, 1'b1, 0, "q_alt");
    run_phase(0, 0, 20000, 1'b1, 64, "q_wrap");
    check_eq("wrap_valid_count", 32'(vcnt), 32'd5000);

    // Reset mid-window at edge 5, then ones again.
    settle_chk = 1'b1;
    settle_val = 64;
    run_cycle(0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) run_cycle(0, 1'b1, 1'b0);
    run_cycle(0, 1'b1, 1'b1);
    settle_n = 0;
    for (int i = 0; i < 40; i++) run_cycle(0, 1'b1, 1'b0);
    check_eq("post_rst_valid_count", 32'(vcnt), 32'd10);
    check_eq("post_rst_settled_n", 32'(settle_n), 32'd7);
    end_phase("q_reset");

    // Default configuration, density 0.75.
    run_phase(1, 3, 32768, 1'b0, 0, "q_rand");
    check_eq("rand_valid_count", 32'(vcnt), 32'd128);
    mean = (settle_n > 0) ? settle_sum / settle_n : 0;
    mean_ok = (mean >= 64'sd8304722) && (mean <= 64'sd8472494);
    if (!mean_ok) $display("mean observed %0d", mean);
    check_eq("rand_mean", {31'd0, mean_ok}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
